dsp_mac_param: RTL and testbench
================================

# dsp_mac_param

Parametrised, fully pipelined multiply-accumulate block for the DSP inference test suite. It generalises the fixed 20x18 unsigned registered multiplier in four ways: configurable operand and accumulator widths, per-operand signed/unsigned selection, an accumulate/subtract/load feedback mode with optional saturation, and a valid pipeline. It sits between stimulus logic and the result sink in DSP mapping testcases. Its RTL serves as the golden model against the post-synthesis netlist in co-simulation.

## Interface
- `A_WIDTH`, default 20: operand A width; legal range 2–32.
- `B_WIDTH`, default 18: operand B width; legal range 2–32.
- `ACC_WIDTH`, default 48: accumulator/output width; must be ≥ A_WIDTH+B_WIDTH (elaboration error otherwise).
- `SATURATE`, default 0: 1 clamps accumulator on overflow; 0 wraps modulo 2^ACC_WIDTH.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  **synchronous, active-low reset**; sampled only on a `clk` rising edge.
- `in_valid`  in  1  qualifies A, B, a_signed, b_signed, mode this cycle.
- `A`  in  A_WIDTH  multiplicand.
- `B`  in  B_WIDTH  multiplier.
- `a_signed`  in  1  1: A is two's complement; 0: unsigned.
- `b_signed`  in  1  1: B is two's complement; 0: unsigned.
- `mode`  in  2  00 multiply, 01 accumulate-add, 10 load, 11 accumulate-subtract.
- `P`  out  ACC_WIDTH  registered result/accumulator.
- `out_valid`  out  1  P updated by a valid operation this cycle.
- `overflow`  out  1  sticky accumulate overflow flag.

## Operation
- Stage 1 registers A, B, signedness bits, mode and valid when `in_valid`=1; otherwise it loads valid=0 and holds the operands.
- Stage 2 forms the full product at width A_WIDTH+B_WIDTH.
  - Each operand is extended by one bit: sign-extended if its signed bit is 1, zero-extended if 0.
  - The (A_WIDTH+1)x(B_WIDTH+1) product is then truncated to A_WIDTH+B_WIDTH bits; this is exact for every signedness combination.
- Result signedness: rs = a_signed | b_signed. The product is extended to ACC_WIDTH with sign-extension if rs=1, zero-extension if rs=0.
- Stage 3 updates P only when stage-2 valid=1:
  - mode 00: P = product.
  - mode 10: P = product.
  - mode 01: P = P + product.
  - mode 11: P = P − product.
- Overflow is evaluated only for modes 01 and 11, using rs of the current operation.
  - Signed overflow: operand signs equal and result sign differs.
  - Unsigned overflow: carry-out on add, borrow on subtract.
- When SATURATE=1 and overflow occurs:
  - Signed: clamp to 2^(ACC_WIDTH−1)−1 (positive) or −2^(ACC_WIDTH−1) (negative).
  - Unsigned: clamp to all-ones (add) or 0 (subtract).
- When SATURATE=0 the result wraps modulo 2^ACC_WIDTH.
- `overflow` sets on any overflow and stays set. It clears on reset or on a valid mode 00/10 operation, and the same update cycle writes 0.
- Bubbles (valid=0) leave P and `overflow` unchanged.
- No backpressure; the block accepts one operation per cycle unconditionally.

## Timing
- Latency is 3 rising edges. An operation sampled at edge N appears on P with `out_valid`=1 after edge N+3.
- `out_valid` is a registered copy of stage-2 valid and is high for exactly one cycle per accepted operation.
- Throughput is 1 operation/cycle.
- Back-to-back accumulate ops chain correctly: stage 3 feeds P back combinationally within one cycle.
- Reset: on a rising edge with `reset`=0, every stage register, P, `out_valid` and `overflow` go to 0.
  - Operations in flight are discarded, never emitted.
  - `in_valid` is ignored while `reset`=0.
- Reset deasserted at edge R: the first operation can be sampled at edge R+1 and emerges at R+4.
- Simultaneous reset and valid input: reset wins.
- An accumulate (mode 01/11) as the first op after reset accumulates onto P=0.

## Test plan
- **Reset.** Hold `reset`=0 for 2 edges with in_valid=1, A=5, B=7 → P=0, out_valid=0, overflow=0. Release; nothing emerges for 3 edges.
- **Unsigned corner.** Defaults, A=20'hFFFFF, B=18'h3FFFF, unsigned, mode 00 → after 3 edges P=48'h003F_FFEC_0001, out_valid pulses once.
- **Signedness.** Run each back-to-back, mode 00, A=20'hFFFFF, B=18'h3FFFF:
  - both signed → P=1.
  - a_signed=1, b_signed=0 → P=48'hFFFF_FFFC_0001.
  - a_signed=0, b_signed=1 → P=48'hFFFF_FFF0_0001 (−0xFFFFF).
- **Accumulate chain.** Consecutive cycles, unsigned: load 3x4, add 5x6, sub 2x1 → P=12, 42, 40 on three consecutive out_valid cycles. Insert a bubble mid-chain → same final 40, one cycle later.
- **Saturation.** ACC_WIDTH=38, SATURATE=1: load 20'hFFFFF x 18'h3FFFF, then add the same → P=38'h3F_FFFF_FFFF, overflow=1. A following mode 00 op with 1x1 → P=1, overflow=0. With SATURATE=0 the same add → wrapped P=38'h3F_FFD8_0002, overflow=1.
- **Reset mid-flight.** Issue 3 ops, pull reset low on the edge after the third → no out_valid for any of them, P=0.

Source files
------------

// File: rtl/dsp_mac_param.sv
// Parametrised pipelined multiply-accumulate: signed/unsigned operands, load/add/sub feedback, optional saturation.
// Latency: an operation sampled on edge N is visible on P (out_valid=1) after edge N+3; one op per cycle.
// Backpressure: none; every in_valid cycle is accepted unconditionally.
//
// Ports:
//   clk, reset            single clock, synchronous active-low reset
//   in_valid, A, B        operation qualifier and operands
//   a_signed, b_signed    per-operand two's complement select
//   mode                  00 multiply, 01 accumulate-add, 10 load, 11 accumulate-subtract
//   P, out_valid          registered result/accumulator and its one-cycle update strobe
//   overflow              sticky accumulate overflow, cleared by mode 00/10 or reset
module dsp_mac_param #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic [1:0]           mode,
    output logic [ACC_WIDTH-1:0] P,
    output logic                 out_valid,
    output logic                 overflow
);

    localparam int PW = A_WIDTH + B_WIDTH;

    if (A_WIDTH < 2 || A_WIDTH > 32) begin : g_bad_a_width
        $error("A_WIDTH must be in 2..32");
    end
    if (B_WIDTH < 2 || B_WIDTH > 32) begin : g_bad_b_width
        $error("B_WIDTH must be in 2..32");
    end
    if (ACC_WIDTH < PW) begin : g_bad_acc_width
        $error("ACC_WIDTH must be at least A_WIDTH+B_WIDTH");
    end

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_SUB  = 2'b11
    } mode_e;

    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Stage 1: operand capture
    logic [A_WIDTH-1:0]   s1_a;
    logic [B_WIDTH-1:0]   s1_b;
    logic                 s1_as, s1_bs, s1_vld;
    mode_e                s1_mode;
    // Stage 2: raw product
    logic [PW-1:0]        s2_prod;
    logic                 s2_rs, s2_vld;
    mode_e                s2_mode;
    // Stage 3: product aligned to accumulator width
    logic [ACC_WIDTH-1:0] s3_prod;
    logic                 s3_rs, s3_vld;
    mode_e                s3_mode;

    // Extending each operand to PW bits and keeping the low PW bits of the
    // product gives the same bits as the (A+1)x(B+1) extended product truncated
    // to PW, for every signedness combination.
    logic [PW-1:0] a_w, b_w, prod_w;

    always_comb begin
        a_w    = s1_as ? PW'($signed(s1_a)) : PW'(s1_a);
        b_w    = s1_bs ? PW'($signed(s1_b)) : PW'(s1_b);
        prod_w = a_w * b_w;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_as   <= 1'b0;
            s1_bs   <= 1'b0;
            s1_mode <= MODE_MUL;
            s1_vld  <= 1'b0;
            s2_prod <= '0;
            s2_rs   <= 1'b0;
            s2_mode <= MODE_MUL;
            s2_vld  <= 1'b0;
            s3_prod <= '0;
            s3_rs   <= 1'b0;
            s3_mode <= MODE_MUL;
            s3_vld  <= 1'b0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_a    <= A;
                s1_b    <= B;
                s1_as   <= a_signed;
                s1_bs   <= b_signed;
                s1_mode <= mode_e'(mode);
            end
            s2_prod <= prod_w;
            s2_rs   <= s1_as | s1_bs;
            s2_mode <= s1_mode;
            s2_vld  <= s1_vld;
            s3_prod <= s2_rs ? ACC_WIDTH'($signed(s2_prod)) : ACC_WIDTH'(s2_prod);
            s3_rs   <= s2_rs;
            s3_mode <= s2_mode;
            s3_vld  <= s2_vld;
        end
    end

    // Accumulator feedback: P is used directly so back-to-back accumulates chain.
    logic                 is_acc, is_sub, ovf_u, ovf_s, ovf;
    logic [ACC_WIDTH:0]   acc_ext;
    logic [ACC_WIDTH-1:0] acc_res, sat_val, p_next;

    always_comb begin
        is_acc  = (s3_mode == MODE_ADD) || (s3_mode == MODE_SUB);
        is_sub  = (s3_mode == MODE_SUB);
        acc_ext = is_sub ? ({1'b0, P} - {1'b0, s3_prod})
                         : ({1'b0, P} + {1'b0, s3_prod});
        acc_res = acc_ext[ACC_WIDTH-1:0];
        // Extra top bit is the carry on add and the borrow on subtract.
        ovf_u   = acc_ext[ACC_WIDTH];
        // Subtract overflows when P and the product differ in sign (i.e. P and
        // the negated product agree) and the result sign leaves P's sign.
        ovf_s   = (is_sub ? (P[ACC_WIDTH-1] != s3_prod[ACC_WIDTH-1])
                          : (P[ACC_WIDTH-1] == s3_prod[ACC_WIDTH-1]))
                  && (acc_res[ACC_WIDTH-1] != P[ACC_WIDTH-1]);
        ovf     = is_acc && (s3_rs ? ovf_s : ovf_u);
        // Signed overflow direction always follows P's sign.
        if (s3_rs) begin
            sat_val = P[ACC_WIDTH-1] ? SMIN : SMAX;
        end else begin
            sat_val = is_sub ? '0 : '1;
        end
        if (!is_acc) begin
            p_next = s3_prod;
        end else if (ovf && (SATURATE != 0)) begin
            p_next = sat_val;
        end else begin
            p_next = acc_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            P         <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= s3_vld;
            if (s3_vld) begin
                P        <= p_next;
                overflow <= is_acc ? (overflow | ovf) : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_param.sv
// Self-checking bench for dsp_mac_param: three instances (48-bit wrap, 38-bit saturate, 38-bit wrap)
// share one randomized stimulus stream; an arithmetic reference model is checked every cycle,
// and directed scenarios pin literal values.
module tb_dsp_mac_param;

    localparam int MAXE = 4096;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, a_signed, b_signed;
    logic [19:0] A;
    logic [17:0] B;
    logic [1:0]  mode;
    logic [47:0] p0;
    logic [37:0] p1, p2;
    logic        v0, v1, v2, o0, o1, o2;

    dsp_mac_param #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(48), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B),
        .a_signed(a_signed), .b_signed(b_signed), .mode(mode),
        .P(p0), .out_valid(v0), .overflow(o0));
    dsp_mac_param #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(38), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B),
        .a_signed(a_signed), .b_signed(b_signed), .mode(mode),
        .P(p1), .out_valid(v1), .overflow(o1));
    dsp_mac_param #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(38), .SATURATE(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B),
        .a_signed(a_signed), .b_signed(b_signed), .mode(mode),
        .P(p2), .out_valid(v2), .overflow(o2));

    typedef struct packed {
        logic        vld;
        logic [19:0] a;
        logic [17:0] b;
        logic        as;
        logic        bs;
        logic [1:0]  mode;
    } op_t;

    op_t    hist [MAXE];
    logic   rst_hist [MAXE];
    int     edge_n = 0;
    int     total = 0;
    int     bad = 0;

    longint m_p  [3];
    bit     m_ov [3];
    bit     m_v;
    int     acc_w [3] = '{48, 38, 38};
    bit     sat   [3] = '{1'b0, 1'b1, 1'b0};

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp, input int e);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%h want=%h", nm, e, got, exp);
        end
    endtask

    // Mathematical value of the operand product.
    function automatic longint prod_val(input op_t o);
        longint av, bv;
        av = longint'(o.a);
        bv = longint'(o.b);
        if (o.as && o.a[19]) av = av - (longint'(1) << 20);
        if (o.bs && o.b[17]) bv = bv - (longint'(1) << 18);
        return av * bv;
    endfunction

    // Apply one operation to instance i using range arithmetic on true values.
    task automatic model_step(input int i, input op_t o);
        longint two_w, pr, cur, r, lo, hi;
        bit     rs;
        two_w = longint'(1) << acc_w[i];
        pr    = prod_val(o);
        rs    = o.as | o.bs;
        if (o.mode == 2'b00 || o.mode == 2'b10) begin
            m_p[i]  = pr & (two_w - 1);
            m_ov[i] = 1'b0;
        end else begin
            cur = m_p[i];
            if (rs && cur >= two_w / 2) cur = cur - two_w;
            r  = (o.mode == 2'b01) ? cur + pr : cur - pr;
            lo = rs ? -(two_w / 2) : 0;
            hi = rs ? (two_w / 2 - 1) : (two_w - 1);
            if (r < lo || r > hi) begin
                m_ov[i] = 1'b1;
                if (sat[i]) r = (r < lo) ? lo : hi;
            end
            m_p[i] = r & (two_w - 1);
        end
    endtask

    // Every-cycle compare: op sampled at edge e-3 shows up after edge e unless
    // reset was low on any edge from its sampling through e.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            hist[edge_n]     = '{in_valid, A, B, a_signed, b_signed, mode};
            rst_hist[edge_n] = reset;
            #1;
            m_v = 1'b0;
            if (!rst_hist[edge_n]) begin
                for (int i = 0; i < 3; i++) begin
                    m_p[i]  = 0;
                    m_ov[i] = 1'b0;
                end
            end else if (edge_n > 3 && hist[edge_n-3].vld && rst_hist[edge_n-3]
                         && rst_hist[edge_n-2] && rst_hist[edge_n-1]) begin
                m_v = 1'b1;
                for (int i = 0; i < 3; i++) model_step(i, hist[edge_n-3]);
            end
            cmp("p0", {16'b0, p0}, m_p[0], edge_n);
            cmp("p1", {26'b0, p1}, m_p[1], edge_n);
            cmp("p2", {26'b0, p2}, m_p[2], edge_n);
            cmp("vld0", {63'b0, v0}, {63'b0, m_v}, edge_n);
            cmp("vld1", {63'b0, v1}, {63'b0, m_v}, edge_n);
            cmp("vld2", {63'b0, v2}, {63'b0, m_v}, edge_n);
            cmp("ovf0", {63'b0, o0}, {63'b0, m_ov[0]}, edge_n);
            cmp("ovf1", {63'b0, o1}, {63'b0, m_ov[1]}, edge_n);
            cmp("ovf2", {63'b0, o2}, {63'b0, m_ov[2]}, edge_n);
        end
    end

    task automatic op(input logic [19:0] a, input logic [17:0] b, input logic as,
                      input logic bs, input logic [1:0] md);
        A = a; B = b; a_signed = as; b_signed = bs; mode = md; in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b1; A = 20'd5; B = 18'd7;
        a_signed = 1'b0; b_signed = 1'b0; mode = 2'b00;
        @(negedge clk);
        @(negedge clk);
        cmp("rst_p", {16'b0, p0}, 64'd0, edge_n);
        cmp("rst_vld", {63'b0, v0}, 64'd0, edge_n);
        cmp("rst_ovf", {63'b0, o1}, 64'd0, edge_n);

        // Release with an op present on the first high edge: silent for 3 edges.
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp("rel_quiet", {63'b0, v0}, 64'd0, edge_n);
            @(negedge clk);
        end
        cmp("rel_first_vld", {63'b0, v0}, 64'd1, edge_n);
        cmp("rel_first_p", {16'b0, p0}, 64'd35, edge_n);

        // Unsigned corner, single pulse.
        op(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 2'b00);
        idle(3);
        cmp("uns_corner", {16'b0, p0}, 64'h003F_FFEC_0001, edge_n);
        cmp("uns_vld", {63'b0, v0}, 64'd1, edge_n);
        idle(1);
        cmp("uns_pulse", {63'b0, v0}, 64'd0, edge_n);

        // Signedness combinations back to back.
        op(20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 2'b00);
        op(20'hFFFFF, 18'h3FFFF, 1'b1, 1'b0, 2'b00);
        op(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b1, 2'b00);
        idle(1);
        cmp("ss", {16'b0, p0}, 64'h0000_0000_0001, edge_n);
        idle(1);
        cmp("su", {16'b0, p0}, 64'hFFFF_FFFC_0001, edge_n);
        idle(1);
        cmp("us", {16'b0, p0}, 64'hFFFF_FFF0_0001, edge_n);

        // Accumulate chain.
        op(20'd3, 18'd4, 1'b0, 1'b0, 2'b10);
        op(20'd5, 18'd6, 1'b0, 1'b0, 2'b01);
        op(20'd2, 18'd1, 1'b0, 1'b0, 2'b11);
        idle(1);
        cmp("chain_load", {16'b0, p0}, 64'd12, edge_n);
        idle(1);
        cmp("chain_add", {16'b0, p0}, 64'd42, edge_n);
        idle(1);
        cmp("chain_sub", {16'b0, p0}, 64'd40, edge_n);
        op(20'd3, 18'd4, 1'b0, 1'b0, 2'b10);
        op(20'd5, 18'd6, 1'b0, 1'b0, 2'b01);
        idle(1);
        op(20'd2, 18'd1, 1'b0, 1'b0, 2'b11);
        idle(3);
        cmp("bubble_chain", {16'b0, p0}, 64'd40, edge_n);
        cmp("bubble_vld", {63'b0, v0}, 64'd1, edge_n);

        // Unsigned add overflow: saturate vs wrap vs wide accumulator.
        op(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 2'b10);
        op(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 2'b01);
        idle(3);
        cmp("sat_p", {26'b0, p1}, 64'h3F_FFFF_FFFF, edge_n);
        cmp("sat_ovf", {63'b0, o1}, 64'd1, edge_n);
        cmp("wrap_p", {26'b0, p2}, 64'h3F_FFD8_0002, edge_n);
        cmp("wrap_ovf", {63'b0, o2}, 64'd1, edge_n);
        cmp("wide_p", {16'b0, p0}, 64'h7F_FFD8_0002, edge_n);
        cmp("wide_ovf", {63'b0, o0}, 64'd0, edge_n);
        op(20'd1, 18'd1, 1'b0, 1'b0, 2'b00);
        idle(3);
        cmp("clr_p", {26'b0, p1}, 64'd1, edge_n);
        cmp("clr_ovf", {63'b0, o1}, 64'd0, edge_n);

        // Signed subtract overflow toward the negative limit.
        op(20'h80000, 18'h1FFFF, 1'b1, 1'b1, 2'b10);
        op(20'h80000, 18'h20000, 1'b1, 1'b1, 2'b11);
        op(20'h80000, 18'h20000, 1'b1, 1'b1, 2'b11);
        idle(2);
        cmp("ssub_first", {26'b0, p1}, 64'h20_0008_0000, edge_n);
        cmp("ssub_first_ovf", {63'b0, o1}, 64'd0, edge_n);
        idle(1);
        cmp("ssub_sat", {26'b0, p1}, 64'h20_0000_0000, edge_n);
        cmp("ssub_sat_ovf", {63'b0, o1}, 64'd1, edge_n);
        cmp("ssub_wrap", {26'b0, p2}, 64'h10_0008_0000, edge_n);

        // Reset while three ops are in flight.
        op(20'd3, 18'd3, 1'b0, 1'b0, 2'b00);
        op(20'd4, 18'd4, 1'b0, 1'b0, 2'b00);
        op(20'd5, 18'd5, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        idle(1);
        cmp("mid_rst_p", {16'b0, p0}, 64'd0, edge_n);
        cmp("mid_rst_vld", {63'b0, v0}, 64'd0, edge_n);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            cmp("mid_rst_quiet", {63'b0, v0}, 64'd0, edge_n);
        end

        // Randomized traffic with biased operands and occasional resets.
        repeat (600) begin
            reset    = ($urandom_range(0, 99) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: A = 20'($urandom);
                1: A = 20'hFFFFF;
                2: A = 20'h80000;
                default: A = 20'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 3))
                0: B = 18'($urandom);
                1: B = 18'h3FFFF;
                2: B = 18'h20000;
                default: B = 18'($urandom_range(0, 15));
            endcase
            a_signed = 1'($urandom);
            b_signed = 1'($urandom);
            mode     = 2'($urandom);
            @(negedge clk);
        end
        reset = 1'b1;
        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
